// File: rtl/cfa_bilinear_demosaic.sv
// rtl/cfa_bilinear_demosaic.sv - streaming 3x3 bilinear Bayer demosaic (optional CFA_BYPASS_EN raw pass-through)
module cfa_bilinear_demosaic #(
    parameter int DW         = 8,
    parameter int MAX_H      = 1024,
    parameter int BORDER_VAL = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [1:0]    cfg_pattern,
`ifdef CFA_BYPASS_EN
    input  logic          cfg_bypass,
`endif
    input  logic          in_vsync,
    input  logic          in_hsync,
    input  logic          in_den,
    input  logic [DW-1:0] in_raw,
    output logic          out_vsync,
    output logic          out_hsync,
    output logic          out_den,
    output logic [DW-1:0] out_data_R,
    output logic [DW-1:0] out_data_G,
    output logic [DW-1:0] out_data_B
);

    localparam int AW = (MAX_H > 1) ? $clog2(MAX_H) : 1;
    localparam int SW = DW + 2;

    // Position counters and frame-level configuration
    logic          vsync_q, hsync_q, line_seen;
    logic [AW-1:0] x_cnt;
    logic [11:0]   y_cnt, y_cur;
    logic [1:0]    pat_q;
    logic          vs_rise, hs_rise;
`ifdef CFA_BYPASS_EN
    logic          byp_q;
`endif

    // Stage registers: sync delay line and per-pixel side information
    logic [2:0]    sd1, sd2, sd3;
    logic [DW-1:0] raw1, rd0, rd1;
    logic [AW-1:0] wa1;
    logic          border0, border1, border2;
    logic [1:0]    phase0, phase1, phase2;

    // Line buffers (no reset: contents are don't-care until overwritten)
    logic [DW-1:0] lb0 [MAX_H];
    logic [DW-1:0] lb1 [MAX_H];

    // 3x3 window, row 0 = oldest line, column 2 = newest pixel
    logic [DW-1:0] win [3][3];

    // Interpolation results
    logic [DW-1:0] c_px, res_r, res_g, res_b;
    logic [SW-1:0] h2, v2, x4, d4;
    logic [DW-1:0] h2r, v2r, x4r, d4r;

    assign vs_rise = in_vsync & ~vsync_q;
    assign hs_rise = in_hsync & ~hsync_q;

    // Line index of the pixel currently on the input; first line of a frame is 0
    always_comb begin
        y_cur = y_cnt;
        if (!in_vsync) begin
            y_cur = '0;
        end else if (hs_rise) begin
            if (!line_seen)
                y_cur = '0;
            else if (y_cnt != 12'hFFF)
                y_cur = y_cnt + 12'd1;
        end
    end

    // Centre is one pixel left and one line up from the newest input
    assign border0 = (x_cnt <= AW'(1)) || (y_cur <= 12'd1);
    assign phase0  = {~y_cur[0] ^ pat_q[1], ~x_cnt[0] ^ pat_q[0]};

    // Counters, edge detectors and pattern latch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vsync_q   <= 1'b0;
            hsync_q   <= 1'b0;
            line_seen <= 1'b0;
            x_cnt     <= '0;
            y_cnt     <= '0;
            pat_q     <= '0;
`ifdef CFA_BYPASS_EN
            byp_q     <= 1'b0;
`endif
        end else begin
            vsync_q   <= in_vsync;
            hsync_q   <= in_hsync;
            y_cnt     <= y_cur;
            line_seen <= in_vsync & (line_seen | hs_rise);
            if (!in_hsync)
                x_cnt <= '0;
            else if (in_den && x_cnt != AW'(MAX_H - 1))
                x_cnt <= x_cnt + AW'(1);
            if (vs_rise) begin
                pat_q <= cfg_pattern;
`ifdef CFA_BYPASS_EN
                byp_q <= cfg_bypass;
`endif
            end
        end
    end

    // Line-buffer RAMs: read-before-write; line 1 is fed from line 0's old word one cycle later
    always_ff @(posedge clk) begin
        if (in_den) begin
            lb0[x_cnt] <= in_raw;
            rd0        <= lb0[x_cnt];
            rd1        <= lb1[x_cnt];
        end
        if (sd1[0])
            lb1[wa1] <= rd0;
    end

    // Stage 1: capture input pixel and its border/phase classification
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sd1     <= '0;
            raw1    <= '0;
            wa1     <= '0;
            border1 <= 1'b0;
            phase1  <= '0;
        end else begin
            sd1 <= {in_vsync, in_hsync, in_den};
            if (in_den) begin
                raw1    <= in_raw;
                wa1     <= x_cnt;
                border1 <= border0;
                phase1  <= phase0;
            end
        end
    end

    // Stage 2: shift the window by one column on each valid pixel
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sd2     <= '0;
            border2 <= 1'b0;
            phase2  <= '0;
            for (int r = 0; r < 3; r++)
                for (int k = 0; k < 3; k++)
                    win[r][k] <= '0;
        end else begin
            sd2 <= sd1;
            if (sd1[0]) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= rd1;
                win[1][2] <= rd0;
                win[2][2] <= raw1;
                border2   <= border1;
                phase2    <= phase1;
            end
        end
    end

    // Neighbour sums and rounded averages for the current centre
    always_comb begin
        c_px = win[1][1];
        h2   = SW'(win[1][0]) + SW'(win[1][2]);
        v2   = SW'(win[0][1]) + SW'(win[2][1]);
        x4   = h2 + v2;
        d4   = SW'(win[0][0]) + SW'(win[0][2]) + SW'(win[2][0]) + SW'(win[2][2]);
        h2r  = DW'((h2 + SW'(1)) >> 1);
        v2r  = DW'((v2 + SW'(1)) >> 1);
        x4r  = DW'((x4 + SW'(2)) >> 2);
        d4r  = DW'((d4 + SW'(2)) >> 2);
    end

    // Select per-site colour, then apply border or bypass overrides
    always_comb begin
        res_r = c_px;
        res_g = c_px;
        res_b = c_px;
        case (phase2)
            2'b00: begin res_r = c_px; res_g = x4r;  res_b = d4r;  end
            2'b01: begin res_r = h2r;  res_g = c_px; res_b = v2r;  end
            2'b10: begin res_r = v2r;  res_g = c_px; res_b = h2r;  end
            default: begin res_r = d4r; res_g = x4r; res_b = c_px; end
        endcase
`ifdef CFA_BYPASS_EN
        if (byp_q) begin
            res_r = c_px;
            res_g = c_px;
            res_b = c_px;
        end else if (border2) begin
            res_r = DW'(BORDER_VAL);
            res_g = DW'(BORDER_VAL);
            res_b = DW'(BORDER_VAL);
        end
`else
        if (border2) begin
            res_r = DW'(BORDER_VAL);
            res_g = DW'(BORDER_VAL);
            res_b = DW'(BORDER_VAL);
        end
`endif
    end

    // Stage 3: registered outputs, data forced to zero outside valid pixels
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sd3        <= '0;
            out_data_R <= '0;
            out_data_G <= '0;
            out_data_B <= '0;
        end else begin
            sd3 <= sd2;
            if (sd2[0]) begin
                out_data_R <= res_r;
                out_data_G <= res_g;
                out_data_B <= res_b;
            end else begin
                out_data_R <= '0;
                out_data_G <= '0;
                out_data_B <= '0;
            end
        end
    end

    assign out_vsync = sd3[2];
    assign out_hsync = sd3[1];
    assign out_den   = sd3[0];

endmodule

// File: tb/tb_cfa_bilinear_demosaic.sv
// tb/tb_cfa_bilinear_demosaic.sv - self-checking bench for cfa_bilinear_demosaic
module tb_cfa_bilinear_demosaic;

    localparam int DW    = 8;
    localparam int MAX_H = 32;
    localparam int BV    = 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    cfg_pattern;
    logic          in_vsync, in_hsync, in_den;
    logic [DW-1:0] in_raw;
    logic          out_vsync, out_hsync, out_den;
    logic [DW-1:0] out_data_R, out_data_G, out_data_B;

    cfa_bilinear_demosaic #(.DW(DW), .MAX_H(MAX_H), .BORDER_VAL(BV)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cfg_pattern (cfg_pattern),
`ifdef CFA_BYPASS_EN
        .cfg_bypass  (1'b0),
`endif
        .in_vsync    (in_vsync),
        .in_hsync    (in_hsync),
        .in_den      (in_den),
        .in_raw      (in_raw),
        .out_vsync   (out_vsync),
        .out_hsync   (out_hsync),
        .out_den     (out_den),
        .out_data_R  (out_data_R),
        .out_data_G  (out_data_G),
        .out_data_B  (out_data_B)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pat; int dpat; int mode; int gaps; int midpat; int simul;
        int w; int h; int er; int eg; int eb;
    } vec_t;

    typedef struct { int x; int y; bit chk; } px_t;

    int  img   [16][16];
    int  got_r [16][16];
    int  got_g [16][16];
    int  got_b [16][16];
    int  total = 0;
    int  bad   = 0;
    int  cur_x = 0, cur_y = 0;
    bit  cur_chk = 1'b0;
    int  frame_pat = 0;
    int  exp_r = -1, exp_g = -1, exp_b = -1;
    px_t pq [$];
    logic [2:0] hist [$];
    vec_t vt [13];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    function automatic string pat_name(input int p);
        case (p)
            0: return "RGGB";
            1: return "GRBG";
            2: return "GBRG";
            default: return "BGGR";
        endcase
    endfunction

    // Reference: colour of the centre site from the pattern letters, then bilinear averages
    function automatic void model(input int x, input int y, output int r, output int g, output int b);
        string s;
        byte   site, other;
        int    xc, yc, c, hs, vs, cr, dg;
        if (x <= 1 || y <= 1) begin
            r = BV; g = BV; b = BV;
            return;
        end
        xc = x - 1; yc = y - 1;
        s = pat_name(frame_pat);
        site  = s[(yc % 2) * 2 + (xc % 2)];
        other = s[(yc % 2) * 2 + 1 - (xc % 2)];
        c  = img[yc][xc];
        hs = img[yc][xc-1] + img[yc][xc+1];
        vs = img[yc-1][xc] + img[yc+1][xc];
        cr = hs + vs;
        dg = img[yc-1][xc-1] + img[yc-1][xc+1] + img[yc+1][xc-1] + img[yc+1][xc+1];
        if (site == "R") begin
            r = c; g = (cr + 2) / 4; b = (dg + 2) / 4;
        end else if (site == "B") begin
            r = (dg + 2) / 4; g = (cr + 2) / 4; b = c;
        end else if (other == "R") begin
            r = (hs + 1) / 2; g = c; b = (vs + 1) / 2;
        end else begin
            r = (vs + 1) / 2; g = c; b = (hs + 1) / 2;
        end
    endfunction

    task automatic fill_img(input int mode, input int dpat, input int w, input int h);
        string s;
        byte   l;
        s = pat_name(dpat);
        for (int yy = 0; yy < h; yy++)
            for (int xx = 0; xx < w; xx++) begin
                case (mode)
                    0: img[yy][xx] = 100;
                    1: begin
                        l = s[(yy % 2) * 2 + (xx % 2)];
                        img[yy][xx] = (l == "R") ? 200 : (l == "B") ? 50 : 100;
                    end
                    2: img[yy][xx] = int'($urandom_range(0, 255));
                    3: img[yy][xx] = 255;
                    default: img[yy][xx] = 2;
                endcase
            end
        if (mode == 4) begin
            img[1][2] = 1;
            img[2][2] = 0;
            img[2][4] = 1;
        end
        for (int yy = 0; yy < 16; yy++)
            for (int xx = 0; xx < 16; xx++) begin
                got_r[yy][xx] = -1; got_g[yy][xx] = -1; got_b[yy][xx] = -1;
            end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #1 reset_n = 1'b0;
        #1;
        check("async_rst_den",   {31'd0, out_den},   32'd0);
        check("async_rst_vsync", {31'd0, out_vsync}, 32'd0);
        check("async_rst_hsync", {31'd0, out_hsync}, 32'd0);
        check("async_rst_rgb",   {8'd0, out_data_R, out_data_G, out_data_B}, 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic send_frame(input vec_t v, input int rst_line);
        cfg_pattern = 2'(v.pat);
        frame_pat   = v.pat;
        cur_chk     = 1'b1;
        exp_r = v.er; exp_g = v.eg; exp_b = v.eb;
        if (v.simul == 0) begin
            in_vsync = 1'b1;
            tick(); tick();
        end
        for (int yy = 0; yy < v.h; yy++) begin
            in_vsync = 1'b1;
            in_hsync = 1'b1;
            cur_y    = yy;
            for (int xx = 0; xx < v.w; xx++) begin
                if (v.midpat >= 0 && yy == v.h / 2 && xx == 0)
                    cfg_pattern = 2'(v.midpat);
                if (v.gaps != 0) begin
                    in_den = 1'b0;
                    tick();
                end
                if (yy == rst_line && xx == v.w / 2) begin
                    do_reset();
                    cur_chk = 1'b0;
                end
                in_den = 1'b1;
                in_raw = DW'(img[yy][xx]);
                cur_x  = xx;
                tick();
            end
            in_den   = 1'b0;
            in_hsync = 1'b0;
            repeat (3) tick();
        end
        in_vsync = 1'b0;
        repeat (6) tick();
    endtask

    int  mr, mg, mb;
    px_t e;

    // Monitor: sync delay, idle zeros, and per-pixel RGB against the reference model
    always @(negedge clk) begin
        if (!reset_n) begin
            pq.delete();
            hist.delete();
        end else begin
            if (hist.size() == 3) begin
                check("sync_delay", {29'd0, out_vsync, out_hsync, out_den}, {29'd0, hist[0]});
                void'(hist.pop_front());
            end
            if (!out_den) begin
                check("idle_zero", {8'd0, out_data_R, out_data_G, out_data_B}, 32'd0);
            end else if (pq.size() == 0) begin
                check("extra_den", 32'd1, 32'd0);
            end else begin
                e = pq.pop_front();
                if (e.x > 1 && e.y > 1) begin
                    got_r[e.y-1][e.x-1] = int'(out_data_R);
                    got_g[e.y-1][e.x-1] = int'(out_data_G);
                    got_b[e.y-1][e.x-1] = int'(out_data_B);
                end
                if (e.chk) begin
                    model(e.x, e.y, mr, mg, mb);
                    check($sformatf("R(%0d,%0d)", e.x, e.y), 32'(out_data_R), 32'(mr));
                    check($sformatf("G(%0d,%0d)", e.x, e.y), 32'(out_data_G), 32'(mg));
                    check($sformatf("B(%0d,%0d)", e.x, e.y), 32'(out_data_B), 32'(mb));
                    if (exp_r >= 0 && e.x > 1 && e.y > 1)
                        check($sformatf("const_rgb(%0d,%0d)", e.x, e.y),
                              {8'd0, out_data_R, out_data_G, out_data_B},
                              {8'd0, 8'(exp_r), 8'(exp_g), 8'(exp_b)});
                end
            end
            hist.push_back({in_vsync, in_hsync, in_den});
            if (in_den)
                pq.push_back('{cur_x, cur_y, cur_chk});
        end
    end

    initial begin
        vt[0]  = '{0, 0, 0, 0, -1, 0,  8, 8, 100, 100, 100};
        vt[1]  = '{0, 0, 1, 0, -1, 0,  8, 8, 200, 100,  50};
        vt[2]  = '{1, 1, 1, 0, -1, 0,  8, 8, 200, 100,  50};
        vt[3]  = '{2, 2, 1, 0, -1, 0,  8, 8, 200, 100,  50};
        vt[4]  = '{3, 3, 1, 0, -1, 0,  8, 8, 200, 100,  50};
        vt[5]  = '{1, 0, 2, 1, -1, 0, 10, 7,  -1,  -1,  -1};
        vt[6]  = '{2, 0, 2, 0, -1, 1, 12, 6,  -1,  -1,  -1};
        vt[7]  = '{3, 0, 3, 0, -1, 0,  6, 6, 255, 255, 255};
        vt[8]  = '{0, 0, 1, 0,  3, 0,  8, 8, 200, 100,  50};
        vt[9]  = '{3, 3, 1, 0, -1, 0,  8, 8, 200, 100,  50};
        vt[10] = '{0, 0, 1, 1, -1, 0,  8, 8, 200, 100,  50};
        vt[11] = '{0, 0, 2, 1, -1, 0,  9, 9,  -1,  -1,  -1};
        vt[12] = '{0, 0, 4, 0, -1, 0,  6, 5,  -1,  -1,  -1};

        reset_n = 1'b0;
        cfg_pattern = 2'd0;
        in_vsync = 1'b0; in_hsync = 1'b0; in_den = 1'b0; in_raw = '0;
        repeat (3) tick();
        check("rst_den",   {31'd0, out_den},   32'd0);
        check("rst_vsync", {31'd0, out_vsync}, 32'd0);
        check("rst_hsync", {31'd0, out_hsync}, 32'd0);
        check("rst_rgb",   {8'd0, out_data_R, out_data_G, out_data_B}, 32'd0);
        reset_n = 1'b1;
        repeat (4) tick();

        for (int i = 0; i < 12; i++) begin
            fill_img(vt[i].mode, vt[i].dpat, vt[i].w, vt[i].h);
            send_frame(vt[i], -1);
        end

        // Rounding corners: cross 1,2,2,2 -> G = 2; G site with h2 = 0+1 -> R = 1
        fill_img(vt[12].mode, vt[12].dpat, vt[12].w, vt[12].h);
        send_frame(vt[12], -1);
        check("corner_rsite_r", 32'(got_r[2][2]), 32'd0);
        check("corner_rsite_g", 32'(got_g[2][2]), 32'd2);
        check("corner_rsite_b", 32'(got_b[2][2]), 32'd2);
        check("corner_gsite_r", 32'(got_r[2][3]), 32'd1);

        // Reset pulsed mid-line, then a full random frame must match the model
        fill_img(2, 0, 10, 8);
        send_frame('{1, 0, 2, 0, -1, 0, 10, 8, -1, -1, -1}, 3);
        fill_img(2, 0, 10, 8);
        send_frame('{2, 0, 2, 1, -1, 0, 10, 8, -1, -1, -1}, -1);

        repeat (10) tick();
        check("drain", 32'(pq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=1 exp=0");
        $fatal(1);
    end

endmodule
